// File: rtl/cram_ld_seq_pkg.sv
// Shared types for the CRAM load sequencer: token structs, FSM states,
// config-word decode and the skid-buffer entry.
package cram_ld_seq_pkg;

    localparam int unsigned WIDTH_DATA = 32;
    localparam int unsigned WIDTH_ADDR = 8;
    localparam int unsigned WIDTH_CNT  = WIDTH_ADDR + 1;
    localparam int unsigned WIDTH_MODE = 2;

    // Config word layout: bit0 decrement, bit1 share, bits3:2 mode.
    localparam int unsigned CFG_BITS      = 4;
    localparam int unsigned CFG_DEC_BIT   = 0;
    localparam int unsigned CFG_SHARE_BIT = 1;
    localparam int unsigned CFG_MODE_LSB  = 2;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
    } BTk_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_LEN,
        ST_STR,
        ST_BASE,
        ST_RUN,
        ST_DRAIN
    } ld_state_e;

    typedef struct packed {
        logic                  dec;
        logic                  share;
        logic [WIDTH_MODE-1:0] mode;
    } cfg_t;

    typedef struct packed {
        logic                  last;
        logic [WIDTH_DATA-1:0] data;
    } skid_ent_t;

    // RAM-flavoured config decode shared with the store sequencer.
    function automatic cfg_t config_dec_ram(input logic [CFG_BITS-1:0] w);
        cfg_t c;
        c.dec   = w[CFG_DEC_BIT];
        c.share = w[CFG_SHARE_BIT];
        c.mode  = w[CFG_MODE_LSB +: WIDTH_MODE];
        return c;
    endfunction

endpackage

// File: rtl/cram_ld_seq_skid.sv
// Two-entry skid FIFO for returning read words; an empty FIFO forwards the
// incoming word straight to the head so an unstalled load costs no extra cycle.
module cram_ld_seq_skid
    import cram_ld_seq_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  skid_ent_t wr_ent,
    input  logic      ready,
    output skid_ent_t head_c,
    output logic      head_valid_c,
    output logic      pop_c,
    output logic [1:0] count,
    output logic      full,
    output logic      empty
);

    skid_ent_t  mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] cnt_q;
    logic       store_c;
    logic       drain_c;

    assign count = cnt_q;
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

    // Head selection with write-through when nothing is stored.
    always_comb begin
        head_valid_c = !empty || push;
        head_c       = empty ? wr_ent : mem[rd_ptr];
        pop_c        = head_valid_c && ready;
        drain_c      = pop_c && !empty;
        store_c      = push && !(empty && pop_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (store_c) begin
                mem[wr_ptr] <= wr_ent;
                wr_ptr      <= ~wr_ptr;
            end
            if (drain_c) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + 2'(store_c) - 2'(drain_c);
        end
    end

endmodule

// File: rtl/cram_ld_seq.sv
// CRAM load sequencer: takes acquire + config tokens, issues strided RAM reads
// and streams the returned words downstream, tagging the last one as release.
module cram_ld_seq
    import cram_ld_seq_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  FTk_t                  I_FTk,
    output BTk_t                  O_BTk,
    output logic                  O_Ld_Req,
    output logic [WIDTH_ADDR-1:0] O_Ld_Addr,
    input  logic [WIDTH_DATA-1:0] I_Ld_Data,
    output FTk_t                  O_FTk,
    input  BTk_t                  I_BTk,
    output logic [WIDTH_MODE-1:0] O_Mode,
    output logic                  O_AccessEnd,
    output logic                  O_Busy
);

    ld_state_e             state_q, state_d;
    logic [WIDTH_MODE-1:0] mode_q, mode_d;
    logic                  dec_q, dec_d;
    logic                  share_q, share_d;
    logic [WIDTH_ADDR-1:0] len_q, len_d;
    logic [WIDTH_ADDR-1:0] stride_q, stride_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_CNT-1:0]  cnt_q, cnt_d;
    logic                  inflight_q;
    logic                  inflight_last_q;

    cfg_t                  cfg_c;
    logic                  issue_c;
    logic                  space_c;
    logic                  clear_c;
    logic                  busy_c;
    skid_ent_t             head_c;
    logic                  head_valid_c;
    logic                  pop_c;
    logic [1:0]            fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  out_valid_c;
    logic                  out_last_c;
    logic                  accept_last_c;
    logic                  unused_c;

    assign unused_c = ^{I_FTk.c, I_FTk.d[WIDTH_DATA-1:WIDTH_ADDR], I_BTk.t, fifo_count};

    // Issue only while stored + in-flight words leave a free FIFO slot.
    assign space_c = fifo_empty || (!fifo_full && !inflight_q);
    assign busy_c  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    cram_ld_seq_skid u_skid (
        .clock        (clock),
        .reset        (reset),
        .push         (inflight_q && !reset),
        .wr_ent       ({inflight_last_q, I_Ld_Data}),
        .ready        (!I_BTk.n),
        .head_c       (head_c),
        .head_valid_c (head_valid_c),
        .pop_c        (pop_c),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    assign out_valid_c   = head_valid_c && !reset;
    assign out_last_c    = out_valid_c && head_c.last;
    assign accept_last_c = out_last_c && pop_c;

    // Next-state, config capture and address/count stepping.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dec_d    = dec_q;
        share_d  = share_q;
        len_d    = len_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        issue_c  = 1'b0;
        clear_c  = 1'b0;
        cfg_c    = config_dec_ram(I_FTk.d[CFG_BITS-1:0]);

        case (state_q)
            ST_IDLE: begin
                if (I_FTk.v && I_FTk.a && !I_FTk.r) begin
                    state_d = ST_CFG;
                end
            end
            ST_CFG: begin
                if (I_FTk.v) begin
                    if (I_FTk.r) begin
                        clear_c = 1'b1;
                    end else begin
                        dec_d   = cfg_c.dec;
                        share_d = cfg_c.share;
                        mode_d  = cfg_c.mode;
                        state_d = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (I_FTk.v) begin
                    if (I_FTk.r) begin
                        clear_c = 1'b1;
                    end else begin
                        len_d   = I_FTk.d[WIDTH_ADDR-1:0];
                        state_d = ST_STR;
                    end
                end
            end
            ST_STR: begin
                if (I_FTk.v) begin
                    if (I_FTk.r) begin
                        clear_c = 1'b1;
                    end else begin
                        stride_d = I_FTk.d[WIDTH_ADDR-1:0];
                        state_d  = ST_BASE;
                    end
                end
            end
            ST_BASE: begin
                if (I_FTk.v) begin
                    if (I_FTk.r) begin
                        clear_c = 1'b1;
                    end else begin
                        addr_d  = I_FTk.d[WIDTH_ADDR-1:0];
                        cnt_d   = WIDTH_CNT'(len_q) + WIDTH_CNT'(share_q) + WIDTH_CNT'(1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!reset && (cnt_q != '0) && space_c) begin
                    issue_c = 1'b1;
                    addr_d  = dec_q ? (addr_q - stride_q) : (addr_q + stride_q);
                    cnt_d   = cnt_q - WIDTH_CNT'(1);
                    if (cnt_q == WIDTH_CNT'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept_last_c) begin
                    clear_c = 1'b1;
                end
            end
            default: begin
                clear_c = 1'b1;
            end
        endcase

        // Abort and load completion both return to a fully cleared IDLE.
        if (clear_c) begin
            state_d  = ST_IDLE;
            mode_d   = '0;
            dec_d    = 1'b0;
            share_d  = 1'b0;
            len_d    = '0;
            stride_d = '0;
            addr_d   = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            mode_q          <= '0;
            dec_q           <= 1'b0;
            share_q         <= 1'b0;
            len_q           <= '0;
            stride_q        <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            dec_q           <= dec_d;
            share_q         <= share_d;
            len_q           <= len_d;
            stride_q        <= stride_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            inflight_q      <= issue_c;
            inflight_last_q <= issue_c && (cnt_q == WIDTH_CNT'(1));
        end
    end

    // Output tokens are driven straight from the FIFO head.
    always_comb begin
        O_FTk   = '0;
        O_FTk.v = out_valid_c;
        O_FTk.a = out_last_c;
        O_FTk.r = out_last_c;
        O_FTk.c = 1'b0;
        O_FTk.d = out_valid_c ? head_c.data : '0;
        O_BTk   = '0;
        O_BTk.n = busy_c;
        O_BTk.t = accept_last_c;
    end

    assign O_Ld_Req    = issue_c;
    assign O_Ld_Addr   = addr_q;
    assign O_Mode      = mode_q;
    assign O_AccessEnd = accept_last_c;
    assign O_Busy      = busy_c;

endmodule

// File: tb/tb_cram_ld_seq.sv
// Directed bench for cram_ld_seq with a one-cycle-latency RAM model.
module tb_cram_ld_seq;
    import cram_ld_seq_pkg::*;

    logic                  clock;
    logic                  reset;
    FTk_t                  I_FTk;
    BTk_t                  O_BTk;
    logic                  O_Ld_Req;
    logic [WIDTH_ADDR-1:0] O_Ld_Addr;
    logic [WIDTH_DATA-1:0] I_Ld_Data;
    FTk_t                  O_FTk;
    BTk_t                  I_BTk;
    logic [WIDTH_MODE-1:0] O_Mode;
    logic                  O_AccessEnd;
    logic                  O_Busy;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  req_addrs [$];
    logic [31:0] tok_d [$];
    logic        tok_last [$];
    int          first_req;
    int          end_pulses;
    int          glitches;
    logic        timed_out;
    logic [1:0]  mode_obs;
    logic        btkn_obs;

    cram_ld_seq dut (
        .clock       (clock),
        .reset       (reset),
        .I_FTk       (I_FTk),
        .O_BTk       (O_BTk),
        .O_Ld_Req    (O_Ld_Req),
        .O_Ld_Addr   (O_Ld_Addr),
        .I_Ld_Data   (I_Ld_Data),
        .O_FTk       (O_FTk),
        .I_BTk       (I_BTk),
        .O_Mode      (O_Mode),
        .O_AccessEnd (O_AccessEnd),
        .O_Busy      (O_Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM: data is a tag plus the address, returned one cycle after the request.
    always @(posedge clock) begin
        I_Ld_Data <= O_Ld_Req ? {24'hC0FFEE, O_Ld_Addr} : 32'h0BAD_0BAD;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_word(input logic a, input logic r, input logic [31:0] d);
        I_FTk.v = 1'b1;
        I_FTk.a = a;
        I_FTk.r = r;
        I_FTk.c = 1'b0;
        I_FTk.d = d;
        @(negedge clock);
        I_FTk = '0;
    endtask

    task automatic send_cfg(input logic [31:0] cfg, input logic [31:0] len,
                            input logic [31:0] stride, input logic [31:0] base);
        send_word(1'b1, 1'b0, 32'h0);
        send_word(1'b0, 1'b0, cfg);
        send_word(1'b0, 1'b0, len);
        send_word(1'b0, 1'b0, stride);
        send_word(1'b0, 1'b0, base);
    endtask

    task automatic do_load(input logic [31:0] cfg, input logic [31:0] len,
                           input logic [31:0] stride, input logic [31:0] base,
                           input int nack_start, input int nack_len);
        logic [31:0] held;
        logic        have_held;
        logic        done;
        req_addrs.delete();
        tok_d.delete();
        tok_last.delete();
        first_req  = -1;
        end_pulses = 0;
        glitches   = 0;
        have_held  = 1'b0;
        held       = '0;
        done       = 1'b0;
        mode_obs   = '0;
        btkn_obs   = 1'b0;
        send_cfg(cfg, len, stride, base);
        for (int cyc = 0; cyc < 300; cyc++) begin
            I_BTk.n = (cyc >= nack_start) && (cyc < nack_start + nack_len);
            #1;
            if (cyc == 0) begin
                mode_obs = O_Mode;
                btkn_obs = O_BTk.n;
            end
            if (O_Ld_Req) begin
                if (first_req < 0) first_req = cyc;
                req_addrs.push_back(O_Ld_Addr);
            end
            if (I_BTk.n) begin
                if (!O_FTk.v || (have_held && O_FTk.d != held)) glitches++;
                held      = O_FTk.d;
                have_held = 1'b1;
            end else begin
                have_held = 1'b0;
            end
            if (O_FTk.v && !I_BTk.n) begin
                tok_d.push_back(O_FTk.d);
                tok_last.push_back(O_FTk.a);
                if (O_FTk.a != O_FTk.r) glitches++;
            end
            if (O_AccessEnd != O_BTk.t) glitches++;
            if (O_AccessEnd) end_pulses++;
            if (cyc > 0 && !O_Busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        I_BTk.n   = 1'b0;
        timed_out = !done;
    endtask

    task automatic cmp_stream(input string tag, input logic [7:0] base,
                              input logic [7:0] stride, input logic dec, input int n);
        logic [7:0] a;
        a = base;
        check({tag, "_timeout"}, 64'(timed_out), 64'(0));
        check({tag, "_first_req"}, 64'(first_req), 64'(0));
        check({tag, "_nreq"}, 64'(req_addrs.size()), 64'(n));
        check({tag, "_ntok"}, 64'(tok_d.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < req_addrs.size())
                check($sformatf("%s_addr%0d", tag, i), 64'(req_addrs[i]), 64'(a));
            if (i < tok_d.size()) begin
                check($sformatf("%s_data%0d", tag, i), 64'(tok_d[i]), 64'({24'hC0FFEE, a}));
                check($sformatf("%s_last%0d", tag, i), 64'(tok_last[i]), 64'(i == n - 1));
            end
            a = dec ? (a - stride) : (a + stride);
        end
        check({tag, "_end_pulses"}, 64'(end_pulses), 64'(1));
        check({tag, "_glitches"}, 64'(glitches), 64'(0));
        check({tag, "_idle_mode"}, 64'(O_Mode), 64'(0));
    endtask

    initial begin
        int nreq;
        reset = 1'b1;
        I_FTk = '0;
        I_BTk = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ftk", 64'(O_FTk), 64'(0));
        check("rst_btk", 64'(O_BTk), 64'(0));
        check("rst_req", 64'({O_Ld_Req, O_Ld_Addr}), 64'(0));
        check("rst_misc", 64'({O_Mode, O_AccessEnd, O_Busy}), 64'(0));
        @(negedge clock);

        // Basic incrementing load: 0x10,0x12,0x14,0x16.
        do_load(32'h4, 32'd3, 32'd2, 32'h10, 1000, 0);
        cmp_stream("t1", 8'h10, 8'd2, 1'b0, 4);
        check("t1_mode", 64'(mode_obs), 64'(1));
        check("t1_btk_n", 64'(btkn_obs), 64'(1));
        check("t1_busy_after", 64'(O_Busy), 64'(0));
        @(negedge clock);

        // Decrement with wrap: 0x02, 0xFF.
        do_load(32'h1, 32'd1, 32'd3, 32'h02, 1000, 0);
        cmp_stream("t2", 8'h02, 8'd3, 1'b1, 2);
        if (req_addrs.size() >= 2) check("t2_wrap_addr", 64'(req_addrs[1]), 64'(8'hFF));
        @(negedge clock);

        // Single word: first is also last.
        do_load(32'h0, 32'd0, 32'd5, 32'h33, 1000, 0);
        cmp_stream("t3", 8'h33, 8'd5, 1'b0, 1);
        @(negedge clock);

        // Share adds one word; upward wrap 0xF8,0x08,0x18,0x28.
        do_load(32'h2, 32'd2, 32'h10, 32'hF8, 1000, 0);
        cmp_stream("t3s", 8'hF8, 8'h10, 1'b0, 4);
        @(negedge clock);

        // Three-cycle nack mid-burst of eight.
        do_load(32'h0, 32'd7, 32'd1, 32'h40, 3, 3);
        cmp_stream("t4", 8'h40, 8'd1, 1'b0, 8);
        @(negedge clock);

        // Release after length word aborts.
        send_word(1'b1, 1'b0, 32'h0);
        send_word(1'b0, 1'b0, 32'h8);
        #1;
        check("t5_mode_cfg", 64'(O_Mode), 64'(2));
        send_word(1'b0, 1'b0, 32'd5);
        send_word(1'b0, 1'b1, 32'h0);
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (O_Ld_Req) nreq++;
            @(negedge clock);
        end
        #1;
        check("t5_nreq", 64'(nreq), 64'(0));
        check("t5_mode", 64'(O_Mode), 64'(0));
        check("t5_busy", 64'(O_Busy), 64'(0));
        // Config-looking words without an acquire start nothing.
        send_word(1'b0, 1'b0, 32'h4);
        send_word(1'b0, 1'b0, 32'd1);
        send_word(1'b0, 1'b0, 32'd1);
        send_word(1'b0, 1'b0, 32'h10);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (O_Ld_Req || O_Busy) nreq++;
            @(negedge clock);
        end
        check("t5_noacq", 64'(nreq), 64'(0));

        // Reset one cycle after the first read.
        send_cfg(32'h4, 32'd3, 32'd1, 32'h20);
        #1;
        check("t6_first_req", 64'({O_Ld_Req, O_Ld_Addr}), 64'({1'b1, 8'h20}));
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_ftk_v_in_rst", 64'(O_FTk.v), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_ftk", 64'(O_FTk), 64'(0));
        check("t6_btk", 64'(O_BTk), 64'(0));
        check("t6_req", 64'({O_Ld_Req, O_Ld_Addr}), 64'(0));
        check("t6_misc", 64'({O_Mode, O_AccessEnd, O_Busy}), 64'(0));
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (O_Ld_Req || O_FTk.v) nreq++;
            @(negedge clock);
        end
        check("t6_quiet", 64'(nreq), 64'(0));
        do_load(32'h4, 32'd2, 32'd4, 32'h80, 1000, 0);
        cmp_stream("t6b", 8'h80, 8'd4, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
